// File: rtl/desplazador_secuencial.sv
// Iterative N-bit shifter: one bit of shift or rotate per clock, driven by a
// start/done handshake. Modes: logical right, arithmetic right, logical left,
// rotate right. Carry holds the last bit shifted out; zero flags an all-zero
// result.
module desplazador_secuencial #(
    parameter int N = 8,
    parameter int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] A,
    input  logic [W-1:0] amt,
    input  logic [1:0]   mode,
    output logic [N-1:0] Y,
    output logic         carry,
    output logic         zero,
    output logic         busy,
    output logic         done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [1:0] M_LSR = 2'b00;
    localparam logic [1:0] M_ASR = 2'b01;
    localparam logic [1:0] M_LSL = 2'b10;
    localparam logic [1:0] M_ROR = 2'b11;

    state_t       state, state_nxt;
    logic [W-1:0] count;
    logic [1:0]   mode_q;
    logic [N-1:0] y_step;
    logic         c_step;

    // State register; reset wins over everything, including an in-flight shift.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state and handshake outputs. The last shift is the one taken with
    // count==1, so DONE follows that edge directly.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = (amt != '0) ? S_SHIFT : S_DONE;
            end
            S_SHIFT: begin
                busy = 1'b1;
                if (count == W'(1)) state_nxt = S_DONE;
            end
            S_DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // One-bit step of the captured mode, applied to the current result.
    always_comb begin
        y_step = Y;
        c_step = 1'b0;
        case (mode_q)
            M_LSR: begin y_step = {1'b0, Y[N-1:1]};   c_step = Y[0];   end
            M_ASR: begin y_step = {Y[N-1], Y[N-1:1]}; c_step = Y[0];   end
            M_LSL: begin y_step = {Y[N-2:0], 1'b0};   c_step = Y[N-1]; end
            M_ROR: begin y_step = {Y[0], Y[N-1:1]};   c_step = Y[0];   end
            default: begin y_step = Y; c_step = 1'b0; end
        endcase
    end

    // Datapath: capture on accepted start, iterate in SHIFT, hold otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            Y      <= '0;
            carry  <= 1'b0;
            zero   <= 1'b0;
            count  <= '0;
            mode_q <= 2'b00;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        Y      <= A;
                        count  <= amt;
                        mode_q <= mode;
                        carry  <= 1'b0;
                        // amt==0 skips SHIFT, so the flag must be settled here.
                        zero   <= (amt == '0) ? (A == '0) : 1'b0;
                    end
                end
                S_SHIFT: begin
                    Y     <= y_step;
                    carry <= c_step;
                    count <= count - W'(1);
                    if (count == W'(1)) zero <= (y_step == '0);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_desplazador_secuencial.sv
// Scoreboard bench for desplazador_secuencial (N=8): each accepted start
// pushes its expected result and done-cycle; the monitor pops on done.
module tb_desplazador_secuencial;

    localparam int N = 8;
    localparam int W = $clog2(N);

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [N-1:0] A;
    logic [W-1:0] amt;
    logic [1:0]   mode;
    logic [N-1:0] Y;
    logic         carry, zero, busy, done;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [N-1:0] y;
        logic         c;
        logic         z;
        int           due;
    } exp_t;

    exp_t sb[$];

    desplazador_secuencial #(.N(N)) dut (
        .clk(clk), .rst(rst), .start(start), .A(A), .amt(amt), .mode(mode),
        .Y(Y), .carry(carry), .zero(zero), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h (cyc %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Independent reference: apply the mode amt times, one bit at a time.
    function automatic exp_t model(input logic [N-1:0] a, input int n, input logic [1:0] m);
        exp_t e;
        e.y = a;
        e.c = 1'b0;
        for (int i = 0; i < n; i++) begin
            case (m)
                2'b00: begin e.c = e.y[0];   e.y = e.y >> 1; end
                2'b01: begin e.c = e.y[0];   e.y = $signed(e.y) >>> 1; end
                2'b10: begin e.c = e.y[N-1]; e.y = e.y << 1; end
                default: begin e.c = e.y[0]; e.y = {e.y[0], e.y[N-1:1]}; end
            endcase
        end
        e.z   = (e.y == '0);
        e.due = 0;
        return e;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin : mon
        exp_t e;
        if (done) begin
            if (sb.size() == 0) begin
                chk("spurious_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("Y", 32'(Y), 32'(e.y));
                chk("carry", 32'(carry), 32'(e.c));
                chk("zero", 32'(zero), 32'(e.z));
                chk("done_cycle", 32'(cyc), 32'(e.due));
                chk("busy_in_done", 32'(busy), 32'd1);
            end
        end
    end

    // Drive one operation with the given expected result, wait for its done.
    task automatic run_op(input logic [N-1:0] a, input logic [W-1:0] n,
                          input logic [1:0] m, input exp_t e);
        exp_t ex;
        int   k;
        @(negedge clk);
        A = a; amt = n; mode = m; start = 1'b1;
        k      = cyc + 1;
        ex     = e;
        ex.due = k + int'(n);
        sb.push_back(ex);
        @(negedge clk);
        start = 1'b0;
        A = ~a; amt = ~n; mode = ~m;    // later input changes must not matter
        chk("busy_after_start", 32'(busy), 32'd1);
        for (int t = 0; t < 40 && sb.size() != 0; t++) @(posedge clk);
        if (sb.size() != 0) begin
            chk("timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    function automatic exp_t mk(input logic [N-1:0] y, input logic c, input logic z);
        exp_t e;
        e.y = y; e.c = c; e.z = z; e.due = 0;
        return e;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] ra;
        logic [W-1:0] rn;
        logic [1:0]   rm;
        rst = 1'b1; start = 1'b0; A = '0; amt = '0; mode = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_Y", 32'(Y), 32'd0);
        chk("rst_flags", {29'd0, carry, zero, busy}, 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        rst = 1'b0;

        run_op(8'hB4, 3'd1, 2'b00, mk(8'h5A, 1'b0, 1'b0));
        run_op(8'h96, 3'd3, 2'b01, mk(8'hF2, 1'b1, 1'b0));
        // Result must hold through idle cycles.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_Y", 32'(Y), 32'hF2);
            chk("hold_carry", 32'(carry), 32'd1);
            chk("idle_busy_done", {30'd0, busy, done}, 32'd0);
        end
        run_op(8'h81, 3'd1, 2'b10, mk(8'h02, 1'b1, 1'b0));
        run_op(8'h01, 3'd7, 2'b11, mk(8'h02, 1'b0, 1'b0));
        run_op(8'h00, 3'd0, 2'b00, mk(8'h00, 1'b0, 1'b1));
        run_op(8'h80, 3'd7, 2'b00, mk(8'h01, 1'b0, 1'b0));
        run_op(8'h01, 3'd1, 2'b00, mk(8'h00, 1'b1, 1'b1));
        run_op(8'h5C, 3'd0, 2'b11, mk(8'h5C, 1'b0, 1'b0));

        // Abort: start ignored mid-shift, then reset aborts the operation.
        @(negedge clk);
        A = 8'hFF; amt = 3'd5; mode = 2'b00; start = 1'b1;   // edge k
        @(negedge clk);
        A = 8'h00; amt = 3'd1; mode = 2'b10;                 // start held into SHIFT
        @(negedge clk);                                      // after edge k+1
        start = 1'b0;
        chk("ignored_start_Y", 32'(Y), 32'h7F);
        chk("ignored_start_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);                                      // after edge k+2
        rst = 1'b0;
        chk("abort_Y", 32'(Y), 32'd0);
        chk("abort_busy_done", {30'd0, busy, done}, 32'd0);
        chk("abort_flags", {30'd0, carry, zero}, 32'd0);
        repeat (8) @(negedge clk);
        chk("abort_no_done_busy", 32'(busy), 32'd0);
        run_op(8'h10, 3'd4, 2'b00, mk(8'h01, 1'b0, 1'b0));

        // Random operations against the reference model.
        for (int i = 0; i < 12; i++) begin
            ra = N'($urandom);
            rn = W'($urandom_range(0, N - 1));
            rm = 2'($urandom);
            run_op(ra, rn, rm, model(ra, int'(rn), rm));
        end

        repeat (3) @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/desplazador_secuencial.md
Name: desplazador_secuencial

Overview:
- Multi-cycle, parametrised shifter for the MicroUAZ datapath.
- Successor to the fixed single-bit right shifter: generalised width N, runtime shift amount, four shift modes, and carry/zero flags.
- Performs one bit of shift per clock under a start/done handshake.
- Targets ALU shift/rotate instructions, where a one-bit-per-cycle iterative implementation saves area over a barrel shifter.

Parameters:
- N, 8, data width in bits; N >= 2.
- W, $clog2(N), width of the shift-amount port (derived; not overridden).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- A  input  N  operand, captured on the accepted start.
- amt  input  W  shift count 0..N-1, captured on the accepted start.
- mode  input  2  shift mode, captured on the accepted start:
  - 00 logical right
  - 01 arithmetic right
  - 10 logical left
  - 11 rotate right
- Y  output  N  result register; holds its value until the next accepted start.
- carry  output  1  last bit shifted or rotated out.
- zero  output  1  high when the result equals 0.
- busy  output  1  high whenever the state is not IDLE.
- done  output  1  one-cycle pulse when the result is valid.

Behaviour:
- One clock domain. Reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset values:
  - Y=0, carry=0, zero=0, busy=0, done=0
  - internal count=0, mode register=00
  - state=IDLE
- Reset has priority over every other input. Asserting rst mid-operation aborts the operation and restores the reset values on that edge.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - On an edge with start=1: Y<=A, count<=amt, mode register<=mode, carry<=0, zero<=0.
  - Next state is SHIFT if amt!=0, else DONE.
  - start=0: stay in IDLE with outputs held.
- SHIFT: each edge performs exactly one 1-bit operation on Y and decrements count.
  - 00: Y<={0,Y[N-1:1]}, carry<=Y[0].
  - 01: Y<={Y[N-1],Y[N-1:1]}, carry<=Y[0].
  - 10: Y<={Y[N-2:0],0}, carry<=Y[N-1].
  - 11: Y<={Y[0],Y[N-1:1]}, carry<=Y[0].
  - The edge on which count goes from 1 to 0 moves the state to DONE. zero<=(next Y==0) on that same edge.
- DONE:
  - done=1 and busy=1 for exactly this one cycle.
  - Next edge moves to IDLE unconditionally.
  - Entering DONE from IDLE (amt=0) sets zero<=(A==0).
- Latency: with start accepted on edge k, done is high during the cycle after edge k+amt. amt=0 therefore gives done one cycle after the start edge.
- start asserted in SHIFT or DONE is ignored entirely; the operation is not queued. The earliest the next start can be accepted is the edge on which the state returns to IDLE, i.e. the first edge seen in IDLE.
- A, amt and mode changes after capture have no effect on the operation in flight.
- Y, carry and zero hold their final values in IDLE until the next accepted start. done is 0 in IDLE.
- Y changes every cycle during SHIFT. Consumers read Y only when done=1 or later.
- amt values >= N are not reachable for power-of-two N. For non-power-of-two N, amt > N-1 is still executed literally, count shifts.

Test Plan:
- After rst, N=8, A=0xB4, amt=1, mode=00, start pulse
  -> busy=1; done pulse 1 cycle after the edge k+1; Y=0x5A, carry=0, zero=0.
- A=0x96, amt=3, mode=01
  -> done at k+3; Y=0xF2, carry=1, zero=0; Y/carry unchanged for 5 further idle cycles.
- A=0x81, amt=1, mode=10 -> Y=0x02, carry=1.
- A=0x01, amt=7, mode=11 -> done at k+7; Y=0x02, carry=0.
- A=0x00, amt=0, mode=00
  -> done in the cycle after the start edge; Y=0x00, zero=1, carry=0.
- Start A=0xFF, amt=5, mode=00; pulse start with A=0x00 during SHIFT; then pulse rst at k+2
  -> the second start does not change Y or count; after rst edge Y=0, busy=0, done=0, state IDLE; a following start with A=0x10, amt=4, mode=00 yields Y=0x01 at done.
